// File: rtl/msk_aes128_key_expander_if.sv
// Handshake/data bundle between the masked AES-128 key expander and its consumer.
// MSK_KS_LAST_KEY_EN adds the sh_last_key output to the bundle.
interface msk_aes128_key_expander_if #(
    parameter int d = 2
);
    localparam int RND_W = 4 * 8 * (d - 1);

    logic                 start;
    logic [128*d-1:0]     sh_key_in;
    logic [RND_W-1:0]     rnd_bus0w;
    logic [RND_W-1:0]     rnd_bus1w;
    logic [RND_W-1:0]     rnd_bus2w;
    logic [RND_W-1:0]     rnd_bus3w;
    logic                 busy;
    logic                 rkey_valid;
    logic [3:0]           rk_idx;
    logic [128*d-1:0]     sh_rkey_out;
`ifdef MSK_KS_LAST_KEY_EN
    logic [128*d-1:0]     sh_last_key;

    modport slave (
        input  start, sh_key_in, rnd_bus0w, rnd_bus1w, rnd_bus2w, rnd_bus3w,
        output busy, rkey_valid, rk_idx, sh_rkey_out, sh_last_key
    );
    modport master (
        output start, sh_key_in, rnd_bus0w, rnd_bus1w, rnd_bus2w, rnd_bus3w,
        input  busy, rkey_valid, rk_idx, sh_rkey_out, sh_last_key
    );
`else
    modport slave (
        input  start, sh_key_in, rnd_bus0w, rnd_bus1w, rnd_bus2w, rnd_bus3w,
        output busy, rkey_valid, rk_idx, sh_rkey_out
    );
    modport master (
        output start, sh_key_in, rnd_bus0w, rnd_bus1w, rnd_bus2w, rnd_bus3w,
        input  busy, rkey_valid, rk_idx, sh_rkey_out
    );
`endif
endinterface

// File: rtl/msk_aes128_key_expander.sv
// Self-sequenced d-share AES-128 key expansion: round keys 0..NROUNDS, one per LATENCY cycles.
// Contains its own LATENCY-deep substitution pipeline; MSK_KS_LAST_KEY_EN adds a held copy of the final key.
module msk_aes128_key_expander #(
    parameter int d       = 2,
    parameter int LATENCY = 4,
    parameter int NROUNDS = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    msk_aes128_key_expander_if.slave   ks
);
    localparam int KW = 128 * d;
    localparam int BW = 8 * d;
    localparam int RW = 8 * (d - 1);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            else      p = p;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse as x^254, then the FIPS-197 affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] inv;
        p   = x;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p   = gf_mul(p, p);
            inv = gf_mul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] unshare(input logic [BW-1:0] sb);
        logic [7:0] v;
        v = 8'h00;
        for (int b = 0; b < 8; b++)
            for (int s = 0; s < d; s++)
                v[b] = v[b] ^ sb[d*b+s];
        return v;
    endfunction

    function automatic logic [BW-1:0] remask(input logic [7:0] v, input logic [RW-1:0] r);
        logic [BW-1:0] o;
        logic [7:0]    last;
        o    = '0;
        last = v;
        for (int s = 0; s < d - 1; s++) begin
            last = last ^ r[8*s +: 8];
            for (int b = 0; b < 8; b++) o[d*b+s] = r[8*s+b];
        end
        for (int b = 0; b < 8; b++) o[d*b+d-1] = last[b];
        return o;
    endfunction

    function automatic logic [BW-1:0] refresh(input logic [BW-1:0] sb, input logic [RW-1:0] r);
        logic [BW-1:0] o;
        o = sb;
        for (int s = 0; s < d - 1; s++)
            for (int b = 0; b < 8; b++) begin
                o[d*b+s]   = o[d*b+s]   ^ r[8*s+b];
                o[d*b+d-1] = o[d*b+d-1] ^ r[8*s+b];
            end
        return o;
    endfunction

    state_e          state_q, state_d;
    logic [KW-1:0]   key_q, key_d;
    logic [3:0]      idx_q, idx_d;
    logic [7:0]      rcon_q, rcon_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
`ifdef MSK_KS_LAST_KEY_EN
    logic [KW-1:0]   last_q, last_d;
`endif

    logic [RW-1:0]   rnd_s  [4][4];
    logic [BW-1:0]   pipe_q [LATENCY-1][4];
    logic [BW-1:0]   pipe_d [LATENCY-1][4];
    logic [BW-1:0]   sub_s  [4];
    logic [BW-1:0]   rc_sh_s;
    logic [KW-1:0]   nk_s;

    // Slice the randomness buses per bus and per sbox.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            rnd_s[0][j] = ks.rnd_bus0w[RW*j +: RW];
            rnd_s[1][j] = ks.rnd_bus1w[RW*j +: RW];
            rnd_s[2][j] = ks.rnd_bus2w[RW*j +: RW];
            rnd_s[3][j] = ks.rnd_bus3w[RW*j +: RW];
        end
    end

    // Substitution pipeline on RotWord(w3); every stage consumes fresh randomness each cycle.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            pipe_d[0][j] = remask(sbox(unshare(key_q[BW*(12 + ((j + 1) % 4)) +: BW])), rnd_s[0][j]);
            for (int k = 1; k < LATENCY - 1; k++)
                pipe_d[k][j] = refresh(pipe_q[k-1][j], rnd_s[k % 4][j]);
            sub_s[j] = refresh(pipe_q[LATENCY-2][j], rnd_s[3][j]);
        end
    end

    // Pipeline registers; never cleared because stale contents are never consumed.
    always_ff @(posedge clk) begin
        pipe_q <= pipe_d;
    end

    // Next round key; RCON enters share 0 only.
    always_comb begin
        rc_sh_s = '0;
        nk_s    = '0;
        for (int b = 0; b < 8; b++) rc_sh_s[d*b] = rcon_q[b];
        for (int i = 0; i < 4; i++)
            nk_s[BW*i +: BW] = sub_s[i] ^ key_q[BW*i +: BW] ^ ((i == 0) ? rc_sh_s : {BW{1'b0}});
        for (int i = 4; i < 16; i++)
            nk_s[BW*i +: BW] = nk_s[BW*(i-4) +: BW] ^ key_q[BW*i +: BW];
    end

    // Sequencer next state.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        rcon_d  = rcon_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
`ifdef MSK_KS_LAST_KEY_EN
        last_d  = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (ks.start) begin
                    key_d   = ks.sh_key_in;
                    idx_d   = 4'd0;
                    rcon_d  = 8'h01;
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            ST_RUN: begin
                if (cnt_q == CW'(LATENCY - 1)) begin
                    cnt_d = {CW{1'b0}};
                    if (idx_q < 4'(NROUNDS)) begin
                        key_d   = nk_s;
                        idx_d   = idx_q + 4'd1;
                        rcon_d  = xtime(rcon_q);
                        valid_d = 1'b1;
`ifdef MSK_KS_LAST_KEY_EN
                        if (idx_q == 4'(NROUNDS - 1)) last_d = nk_s;
                        else                          last_d = last_q;
`endif
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            idx_q   <= 4'd0;
            rcon_q  <= 8'h01;
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef MSK_KS_LAST_KEY_EN
            last_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            rcon_q  <= rcon_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
`ifdef MSK_KS_LAST_KEY_EN
            last_q  <= last_d;
`endif
        end
    end

    assign ks.busy        = busy_q;
    assign ks.rkey_valid  = valid_q;
    assign ks.rk_idx      = idx_q;
    assign ks.sh_rkey_out = key_q;
`ifdef MSK_KS_LAST_KEY_EN
    assign ks.sh_last_key = last_q;
`endif

endmodule
